calc_exec_ctrl: RTL and testbench

Multi-cycle execution controller for the calculator's fixed-point arithmetic. It sits between the input/operation-select state machine and the display path. It accepts one signed-magnitude operand pair plus an operation code per start/done handshake. Add/sub run in one step; multiply/divide are sequenced through a shift-add multiplier and a restoring divider, so no wide combinational `*` or `/` is needed. Values are fixed-point with scale 10000 (four decimal places).

---
 rtl/calc_pkg.sv | 22 ++
 rtl/calc_divu.sv | 53 +++++
 rtl/calc_exec_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_calc_exec_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared encodings for the calculator execution controller.
// Op codes, fixed-point scale and controller state type.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // Fixed-point scale: four decimal places.
  localparam int CALC_SCALE = 10000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDSUB,
    ST_MUL,
    ST_DIV,
    ST_ROUND,
    ST_DONE
  } exec_state_t;

endpackage

// File: rtl/calc_divu.sv
// Restoring divider, 2W-bit dividend by W-bit divisor, one quotient bit per clock.
// done pulses in the clock after the 2W-th step; a new start restarts it, there is no backpressure.
module calc_divu #(
  parameter int W = 40
) (
  input  logic           clk_db,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           done,
  output logic [2*W-1:0] quot,
  output logic [W-1:0]   rem
);

  localparam int CW = $clog2(2*W+1);

  logic [CW-1:0] cnt;
  logic [W-1:0]  dvs;
  logic [W:0]    trial;
  logic [W-1:0]  diff;
  logic          take;

  // quot starts as the dividend and shifts quotient bits in from the bottom.
  assign trial = {rem, quot[2*W-1]};
  assign take  = (trial >= {1'b0, dvs});
  // When take is set the true difference is below dvs, so W bits suffice.
  assign diff  = trial[W-1:0] - dvs;

  always_ff @(posedge clk_db) begin
    if (rst) begin
      cnt  <= '0;
      dvs  <= '0;
      quot <= '0;
      rem  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quot <= dividend;
        rem  <= '0;
        dvs  <= divisor;
        cnt  <= CW'(2*W);
      end else if (cnt != '0) begin
        quot <= {quot[2*W-2:0], take};
        rem  <= take ? diff : trial[W-1:0];
        cnt  <= cnt - CW'(1);
        done <= (cnt == CW'(1));
      end
    end
  end

endmodule

// File: rtl/calc_exec_ctrl.sv
// Signed-magnitude fixed-point add/sub/mul/div sequencer; add/sub/div0 done in cycle 2, mul/div in 3W+2 (3W+3 with CALC_EXEC_ROUND_EN).
// start is sampled only in IDLE; requests while busy or in DONE are dropped, not queued.
module calc_exec_ctrl
  import calc_pkg::*;
#(
  parameter int W = 40
) (
  input  logic         clk_db,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] mag_a,
  input  logic [W-1:0] mag_b,
  input  logic         neg_a,
  input  logic         neg_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         neg_r,
  output logic         ovf,
  output logic         err_div0
);

  localparam logic [W-1:0] SCALE_W = W'(CALC_SCALE);
  localparam int CW = $clog2(W+1);

  exec_state_t state, state_nxt;

  logic [1:0]     op_q;
  logic [W-1:0]   a_q, b_q;
  logic           na_q, nb_q;

  logic [2*W-1:0] acc, acc_nxt, mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  mcnt;

  logic           div_start, div_done;
  logic [2*W-1:0] div_quot;
  logic [W-1:0]   div_rem, dvs;

  logic [2*W:0]   q_ext;
  logic           md_ovf, md_neg;
  logic [W-1:0]   md_res;

  logic           b_eff;
  logic [W:0]     sum;
  logic [W-1:0]   as_res;
  logic           as_neg, as_ovf;

  // Shift-add multiplier: one multiplier bit per MUL cycle.
  assign acc_nxt   = mplier[0] ? (acc + mcand) : acc;
  assign div_start = (state == ST_MUL) && (mcnt == CW'(W-1));
  assign dvs       = (op_q == OP_MUL) ? SCALE_W : b_q;

  calc_divu #(.W(W)) u_divu (
    .clk_db   (clk_db),
    .rst      (rst),
    .start    (div_start),
    .dividend (acc_nxt),
    .divisor  (dvs),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );

`ifdef CALC_EXEC_ROUND_EN
  logic rnd_up;
  assign rnd_up = ({div_rem, 1'b0} >= {1'b0, dvs});
  assign q_ext  = {1'b0, div_quot} + {{(2*W){1'b0}}, rnd_up};
`else
  assign q_ext  = {1'b0, div_quot};
`endif

  assign md_ovf = |q_ext[2*W:W];
  assign md_res = md_ovf ? '1 : q_ext[W-1:0];
  assign md_neg = (na_q ^ nb_q) && (md_res != '0);

  always_comb begin
    b_eff  = nb_q ^ (op_q == OP_SUB);
    sum    = {1'b0, a_q} + {1'b0, b_q};
    as_res = '0;
    as_neg = 1'b0;
    as_ovf = 1'b0;
    if (na_q == b_eff) begin
      as_ovf = sum[W];
      as_res = sum[W] ? '1 : sum[W-1:0];
      as_neg = na_q && (as_res != '0);
    end else if (a_q >= b_q) begin
      as_res = a_q - b_q;
      as_neg = na_q && (as_res != '0);
    end else begin
      as_res = b_q - a_q;
      as_neg = b_eff;
    end
  end

  always_ff @(posedge clk_db) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    case (state)
      ST_IDLE: begin
        if (start) begin
          // Divide by zero resolves in the single-step state, matching add/sub timing.
          if (op == OP_MUL || (op == OP_DIV && mag_b != '0)) state_nxt = ST_MUL;
          else                                                state_nxt = ST_ADDSUB;
        end
      end
      ST_ADDSUB: state_nxt = ST_DONE;
      ST_MUL:    if (div_start) state_nxt = ST_DIV;
      ST_DIV: begin
        if (div_done) begin
`ifdef CALC_EXEC_ROUND_EN
          state_nxt = ST_ROUND;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
      ST_ROUND:  state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_db) begin
    if (rst) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      na_q     <= 1'b0;
      nb_q     <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      mcnt     <= '0;
      result   <= '0;
      neg_r    <= 1'b0;
      ovf      <= 1'b0;
      err_div0 <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q     <= op;
            a_q      <= mag_a;
            b_q      <= mag_b;
            na_q     <= neg_a;
            nb_q     <= neg_b;
            acc      <= '0;
            mcand    <= {{W{1'b0}}, mag_a};
            mplier   <= (op == OP_MUL) ? mag_b : SCALE_W;
            mcnt     <= '0;
            result   <= '0;
            neg_r    <= 1'b0;
            ovf      <= 1'b0;
            err_div0 <= 1'b0;
          end
        end
        ST_ADDSUB: begin
          if (op_q == OP_DIV) begin
            err_div0 <= 1'b1;
          end else begin
            result <= as_res;
            neg_r  <= as_neg;
            ovf    <= as_ovf;
          end
        end
        ST_MUL: begin
          acc    <= acc_nxt;
          mcand  <= {mcand[2*W-2:0], 1'b0};
          mplier <= mplier >> 1;
          mcnt   <= mcnt + CW'(1);
        end
`ifdef CALC_EXEC_ROUND_EN
        ST_ROUND: begin
          result <= md_res;
          neg_r  <= md_neg;
          ovf    <= md_ovf;
        end
`else
        ST_DIV: begin
          if (div_done) begin
            result <= md_res;
            neg_r  <= md_neg;
            ovf    <= md_ovf;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_exec_ctrl.sv
// Bench for calc_exec_ctrl: directed table, held-start and mid-op reset sequences, random ops vs arithmetic model.
module tb_calc_exec_ctrl;
  import calc_pkg::*;

  localparam int W = 40;
`ifdef CALC_EXEC_ROUND_EN
  localparam int L_MD = 3*W + 3;
  localparam bit RND  = 1'b1;
`else
  localparam int L_MD = 3*W + 2;
  localparam bit RND  = 1'b0;
`endif

  logic         clk_db = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] mag_a = '0, mag_b = '0;
  logic         neg_a = 1'b0, neg_b = 1'b0;
  logic         busy, done, neg_r, ovf, err_div0;
  logic [W-1:0] result;

  calc_exec_ctrl #(.W(W)) dut (
    .clk_db   (clk_db),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .neg_a    (neg_a),
    .neg_b    (neg_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .neg_r    (neg_r),
    .ovf      (ovf),
    .err_div0 (err_div0)
  );

  always #5 clk_db = ~clk_db;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         na, nb;
    logic [W-1:0] r;
    logic         nr, ov, e0;
  } vec_t;

  typedef struct {
    logic [W-1:0] r;
    logic         nr, ov, e0;
    int           lat;
  } exp_t;

  function automatic vec_t mk(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic na, input logic nb, input logic [W-1:0] r,
                              input logic nr, input logic ov, input logic e0);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.na = na; v.nb = nb;
    v.r = r; v.nr = nr; v.ov = ov; v.e0 = e0;
    return v;
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] b);
    if (o == OP_ADD || o == OP_SUB || (o == OP_DIV && b == '0)) return 2;
    return L_MD;
  endfunction

  // Reference: signed integer add/sub, wide exact product/quotient for mul/div.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic na, input logic nb);
    exp_t e;
    longint va, vb, s, mag;
    logic [127:0] p, dv, q, rm;
    e.r = '0; e.nr = 1'b0; e.ov = 1'b0; e.e0 = 1'b0;
    e.lat = exp_lat(o, b);
    if (o == OP_ADD || o == OP_SUB) begin
      va  = na ? -longint'(a) : longint'(a);
      vb  = (nb ^ (o == OP_SUB)) ? -longint'(b) : longint'(b);
      s   = va + vb;
      mag = (s < 0) ? -s : s;
      e.ov = (mag >= (longint'(1) << W));
      e.r  = e.ov ? '1 : mag[W-1:0];
      e.nr = (s < 0);
    end else if (o == OP_DIV && b == '0) begin
      e.e0 = 1'b1;
    end else begin
      p  = (o == OP_MUL) ? 128'(a) * 128'(b) : 128'(a) * 128'(CALC_SCALE);
      dv = (o == OP_MUL) ? 128'(CALC_SCALE) : 128'(b);
      q  = p / dv;
      rm = p % dv;
      if (RND && (2 * rm >= dv)) q = q + 128'd1;
      e.ov = (q >= (128'd1 << W));
      e.r  = e.ov ? '1 : q[W-1:0];
      e.nr = (na ^ nb) && (e.r != '0);
    end
    return e;
  endfunction

  // Issue one op from an IDLE cycle, scramble inputs after acceptance, poke start mid-op.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic na, input logic nb,
                        output logic [W-1:0] r, output logic nr, output logic ov,
                        output logic e0, output int lat);
    bit busy_ok, clr_ok;
    op = o; mag_a = a; mag_b = b; neg_a = na; neg_b = nb; start = 1'b1;
    @(posedge clk_db);
    #1;
    start = 1'b0;
    mag_a = W'({$urandom, $urandom});
    mag_b = W'({$urandom, $urandom});
    neg_a = 1'($urandom);
    neg_b = 1'($urandom);
    op    = 2'($urandom);
    lat = 0; busy_ok = 1'b1; clr_ok = 1'b1;
    for (int c = 1; c <= L_MD + 20; c++) begin
      @(negedge clk_db);
      if (c == 1) clr_ok = (result == '0) && !neg_r && !ovf && !err_div0;
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
      if (c == 5) start = 1'b1;
      else if (c == 6) start = 1'b0;
    end
    start = 1'b0;
    r = result; nr = neg_r; ov = ovf; e0 = err_div0;
    chk("busy_during_op", busy_ok, 1);
    chk("status_cleared_on_start", clr_ok, 1);
    @(posedge clk_db);
    #1;
    chk("idle_after_done", {busy, done}, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    exp_t e;
    logic [W-1:0] r, a, b;
    logic nr, ov, e0;
    logic [1:0] o;
    int lat, dn, seen;
    bit na, nb, b3, b4;

    tbl[0]  = mk(OP_MUL, 40'd125000, 40'd20000, 0, 0, 40'd250000, 0, 0, 0);
    tbl[1]  = mk(OP_DIV, 40'd20000,  40'd30000, 0, 0, RND ? 40'd6667 : 40'd6666, 0, 0, 0);
    tbl[2]  = mk(OP_SUB, 40'd30000,  40'd50000, 0, 0, 40'd20000, 1, 0, 0);
    tbl[3]  = mk(OP_SUB, 40'd50000,  40'd50000, 0, 0, 40'd0, 0, 0, 0);
    tbl[4]  = mk(OP_DIV, 40'd90000,  40'd30000, 1, 0, 40'd30000, 1, 0, 0);
    tbl[5]  = mk(OP_DIV, 40'd70000,  40'd0,     0, 1, 40'd0, 0, 0, 1);
    tbl[6]  = mk(OP_MUL, 40'd10000000000, 40'd10000000000, 0, 0, 40'hFF_FFFF_FFFF, 0, 1, 0);
    tbl[7]  = mk(OP_ADD, 40'd30000,  40'd50000, 1, 1, 40'd80000, 1, 0, 0);
    tbl[8]  = mk(OP_ADD, 40'hFF_FFFF_FFFF, 40'd1, 1, 1, 40'hFF_FFFF_FFFF, 1, 1, 0);
    tbl[9]  = mk(OP_MUL, 40'd25000,  40'd40000, 1, 0, 40'd100000, 1, 0, 0);
    tbl[10] = mk(OP_MUL, 40'd0,      40'd50000, 1, 0, 40'd0, 0, 0, 0);
    tbl[11] = mk(OP_DIV, 40'd10000,  40'd30000, 0, 0, 40'd3333, 0, 0, 0);
    tbl[12] = mk(OP_SUB, 40'd70000,  40'd20000, 0, 1, 40'd90000, 0, 0, 0);
    tbl[13] = mk(OP_ADD, 40'd10000,  40'd30000, 1, 0, 40'd20000, 0, 0, 0);
    tbl[14] = mk(OP_SUB, 40'd20000,  40'd50000, 1, 1, 40'd30000, 0, 0, 0);
    tbl[15] = mk(OP_MUL, 40'd10000000000, 40'd10000000000, 1, 0, 40'hFF_FFFF_FFFF, 1, 1, 0);

    // Reset state.
    repeat (3) @(posedge clk_db);
    @(negedge clk_db);
    chk("reset_outputs", {busy, done, neg_r, ovf, err_div0, result}, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].na, tbl[i].nb, r, nr, ov, e0, lat);
      chk($sformatf("tbl%0d_latency", i), lat, exp_lat(tbl[i].op, tbl[i].b));
      chk($sformatf("tbl%0d_result", i), r, tbl[i].r);
      chk($sformatf("tbl%0d_neg_r", i), nr, tbl[i].nr);
      chk($sformatf("tbl%0d_ovf", i), ov, tbl[i].ov);
      chk($sformatf("tbl%0d_err_div0", i), e0, tbl[i].e0);
    end

    // start held through a divide by zero: one done, an IDLE gap, then re-acceptance.
    op = OP_DIV; mag_a = 40'd123; mag_b = '0; neg_a = 1'b0; neg_b = 1'b0; start = 1'b1;
    @(posedge clk_db);
    dn = 0; b3 = 1'b1; b4 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_db);
      if (c <= 3 && done) dn++;
      if (c == 3) b3 = busy;
      if (c == 4) b4 = busy;
    end
    start = 1'b0;
    chk("held_start_one_done", dn, 1);
    chk("held_start_idle_gap", b3, 0);
    chk("held_start_reaccept", b4, 1);
    seen = 0; e0 = 1'b0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk_db);
      if (done) begin
        seen = 1;
        e0 = err_div0;
      end
    end
    chk("reaccept_done", seen, 1);
    chk("reaccept_err_div0", e0, 1);
    @(posedge clk_db);
    #1;

    // Reset in cycle 50 of a multiply.
    op = OP_MUL; mag_a = 40'd125000; mag_b = 40'd20000; start = 1'b1;
    @(posedge clk_db);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 50; c++) @(negedge clk_db);
    chk("busy_before_reset", busy, 1);
    rst = 1'b1;
    @(posedge clk_db);
    #1;
    rst = 1'b0;
    @(negedge clk_db);
    chk("reset_mid_op_outputs", {busy, done, neg_r, ovf, err_div0, result}, 0);
    dn = 0;
    repeat (200) begin
      @(negedge clk_db);
      if (done) dn++;
    end
    chk("no_done_after_reset", dn, 0);
    @(posedge clk_db);
    #1;

    // Random ops against the arithmetic model.
    for (int k = 0; k < 30; k++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       a = W'($urandom_range(0, 2000000));
        1:       a = W'({$urandom, $urandom});
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0:       b = W'($urandom_range(1, 2000000));
        1:       b = W'({$urandom, $urandom});
        default: b = W'($urandom);
      endcase
      if (o == OP_DIV && $urandom_range(0, 7) == 0) b = '0;
      na = 1'($urandom);
      nb = 1'($urandom);
      e = model(o, a, b, na, nb);
      run_op(o, a, b, na, nb, r, nr, ov, e0, lat);
      chk($sformatf("rnd%0d_op%0d_latency", k, o), lat, e.lat);
      chk($sformatf("rnd%0d_op%0d_result", k, o), r, e.r);
      chk($sformatf("rnd%0d_op%0d_neg_r", k, o), nr, e.nr);
      chk($sformatf("rnd%0d_op%0d_ovf", k, o), ov, e.ov);
      chk($sformatf("rnd%0d_op%0d_err_div0", k, o), e0, e.e0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
